byte_a_palabra: RTL and testbench

- Receive-side stage directly downstream of the serial-to-parallel converter in phy_rx.
- Consumes the recovered 8-bit byte stream and its "link active" flag, discards 0xBC comma/idle bytes, and packs consecutive data bytes into 32-bit words with a one-cycle valid strobe.
- Detects and counts framing errors: a word interrupted by a comma or by loss of link.

---
 rtl/phy_rx_pkg.sv | 15 +
 rtl/byte_a_palabra.sv | 111 +++++++++++
 tb/tb_byte_a_palabra.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/phy_rx_pkg.sv
// Shared receive-path definitions for the phy_rx stages.
// Holds the comma/idle byte value and the byte packer state encoding.
// No ports; imported by the rx modules.
package phy_rx_pkg;

  // Idle/alignment byte, shared with the serial-to-parallel and tx stages.
  localparam logic [7:0] COMMA_BC = 8'hBC;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    IDLE    = 2'd1,
    COLLECT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/byte_a_palabra.sv
// Packs the recovered byte stream into NUM_BYTES-wide words, dropping commas.
// Latency: the word and valid_output appear one clk_4f cycle after the last byte.
// No backpressure: one byte is consumed on every clk_4f edge.
//
// Ports:
//   clk_4f        byte clock (single domain)
//   reset         synchronous, active-high
//   active_input  link-aligned flag; a byte is qualified only while it is high
//   data_input    byte from the serial-to-parallel stage
//   data_output   last completed word, first received byte in the MSBs
//   valid_output  one-cycle pulse on each completed word
//   error_output  one-cycle pulse when a partial word is discarded
//   error_count   saturating count of error_output pulses
module byte_a_palabra
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA     = COMMA_BC,
  parameter int         NUM_BYTES = 4,
  parameter int         ERR_W     = 8
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic                     active_input,
  input  logic [7:0]               data_input,
  output logic [8*NUM_BYTES-1:0]   data_output,
  output logic                     valid_output,
  output logic                     error_output,
  output logic [ERR_W-1:0]         error_count
);

  localparam int WORD_W = 8 * NUM_BYTES;
  localparam int CNT_W  = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_BYTES - 1);

  rx_state_t         state, nxt_state;
  logic [CNT_W-1:0]  cnt, nxt_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic              load_first, shift_in, word_done, frame_err;

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    load_first = 1'b0;
    shift_in   = 1'b0;
    word_done  = 1'b0;
    frame_err  = 1'b0;
    case (state)
      UNSYNC: begin
        // Nothing is accepted as data until the first comma is seen.
        if (active_input && data_input == COMMA) nxt_state = IDLE;
      end
      IDLE: begin
        if (!active_input) begin
          nxt_state = UNSYNC;
        end else if (data_input != COMMA) begin
          load_first = 1'b1;
          nxt_cnt    = CNT_W'(1);
          nxt_state  = COLLECT;
        end
      end
      COLLECT: begin
        if (!active_input) begin
          frame_err = 1'b1;
          nxt_cnt   = '0;
          nxt_state = UNSYNC;
        end else if (data_input == COMMA) begin
          frame_err = 1'b1;
          nxt_cnt   = '0;
          nxt_state = IDLE;
        end else if (cnt == LAST_K) begin
          // Final byte: the word completes on this edge and IDLE is only
          // passed through, so a data byte next cycle starts a new word.
          word_done = 1'b1;
          nxt_cnt   = '0;
          nxt_state = IDLE;
        end else begin
          shift_in = 1'b1;
          nxt_cnt  = cnt + 1'b1;
        end
      end
      default: begin
        nxt_cnt   = '0;
        nxt_state = UNSYNC;
      end
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state        <= UNSYNC;
      cnt          <= '0;
      shift_reg    <= '0;
      data_output  <= '0;
      valid_output <= 1'b0;
      error_output <= 1'b0;
      error_count  <= '0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      valid_output <= word_done;
      error_output <= frame_err;
      // Bytes enter at the LSB end and move up, so slot 0 ends in the MSBs.
      if (load_first) shift_reg <= {{(WORD_W-8){1'b0}}, data_input};
      if (shift_in)   shift_reg <= {shift_reg[WORD_W-9:0], data_input};
      if (word_done)  data_output <= {shift_reg[WORD_W-9:0], data_input};
      if (frame_err && error_count != {ERR_W{1'b1}})
        error_count <= error_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_byte_a_palabra.sv
module tb_byte_a_palabra;

  localparam int NB = 4;

  logic        clk_4f = 1'b0;
  logic        reset = 1'b1;
  logic        active_input = 1'b0;
  logic [7:0]  data_input = 8'h00;
  logic [31:0] data_output;
  logic        valid_output;
  logic        error_output;
  logic [7:0]  error_count;

  byte_a_palabra dut (
    .clk_4f       (clk_4f),
    .reset        (reset),
    .active_input (active_input),
    .data_input   (data_input),
    .data_output  (data_output),
    .valid_output (valid_output),
    .error_output (error_output),
    .error_count  (error_count)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct {
    bit          is_err;
    logic [31:0] word;
    logic [7:0]  cnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: a "synced" flag plus the list of bytes of the word in
  // progress. Every step corresponds to one sampling edge.
  bit          m_synced = 0;
  logic [7:0]  m_part[$];
  logic [31:0] m_last = '0;
  int          m_errs = 0;

  function automatic void model_step(input logic rst, input logic act, input logic [7:0] d);
    ev_t e;
    logic [31:0] w;
    if (rst) begin
      m_synced = 0; m_part.delete(); m_last = '0; m_errs = 0;
    end else if (!act || d == 8'hBC) begin
      if (m_part.size() != 0) begin
        if (m_errs < 255) m_errs++;
        e.is_err = 1; e.word = '0; e.cnt = 8'(m_errs);
        exp_q.push_back(e);
      end
      m_part.delete();
      m_synced = act;
    end else if (m_synced) begin
      m_part.push_back(d);
      if (m_part.size() == NB) begin
        w = '0;
        foreach (m_part[i]) w = (w << 8) | 32'(m_part[i]);
        m_last = w;
        e.is_err = 0; e.word = w; e.cnt = 8'(m_errs);
        exp_q.push_back(e);
        m_part.delete();
      end
    end
  endfunction

  task automatic step(input logic rst, input logic act, input logic [7:0] d);
    @(posedge clk_4f);
    #1;
    reset = rst; active_input = act; data_input = d;
    model_step(rst, act, d);
  endtask

  task automatic send(input logic [7:0] s[$]);
    foreach (s[i]) step(1'b0, 1'b1, s[i]);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge clk_4f) begin
    ev_t e;
    if (valid_output === 1'b1 || error_output === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: valid=%b error=%b, expected no pulse", valid_output, error_output);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err) begin
          if (error_output !== 1'b1 || valid_output !== 1'b0 || error_count !== e.cnt) begin
            errors++;
            $display("FAIL error_event: valid=%b error=%b count=%h, expected error pulse count=%h",
                     valid_output, error_output, error_count, e.cnt);
          end
        end else begin
          if (valid_output !== 1'b1 || error_output !== 1'b0 || data_output !== e.word ||
              error_count !== e.cnt) begin
            errors++;
            $display("FAIL word_event: valid=%b error=%b data=%h count=%h, expected word %h count=%h",
                     valid_output, error_output, data_output, error_count, e.word, e.cnt);
          end
        end
      end
    end
  end

  task automatic drain_and_check(input string name);
    step(1'b0, 1'b1, 8'hBC);
    step(1'b0, 1'b1, 8'hBC);
    @(negedge clk_4f);
    @(negedge clk_4f);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_count"}, 32'(error_count), 32'(m_errs));
    chk({name, "_hold"}, data_output, m_last);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] s[$];
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    @(posedge clk_4f);
    @(negedge clk_4f);
    chk("reset_data", data_output, 32'h0);
    chk("reset_valid", 32'(valid_output), 32'h0);
    chk("reset_error", 32'(error_output), 32'h0);
    chk("reset_count", 32'(error_count), 32'h0);

    s = '{8'hBC, 8'hBC, 8'h11, 8'h22, 8'h33, 8'h44, 8'hBC}; send(s);
    drain_and_check("basic");
    s = '{8'hBC, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4}; send(s);
    drain_and_check("b2b");
    s = '{8'hBC, 8'h55, 8'h66, 8'hBC, 8'h01, 8'h02, 8'h03, 8'h04}; send(s);
    drain_and_check("comma_err");
    s = '{8'hBC, 8'h77, 8'h88}; send(s);
    step(1'b0, 1'b0, 8'h0A);
    step(1'b0, 1'b0, 8'hBC);
    s = '{8'h0A, 8'h0B, 8'hBC, 8'h0A, 8'h0B, 8'h0C, 8'h0D}; send(s);
    drain_and_check("link_loss");

    step(1'b1, 1'b0, 8'h00);
    s = '{8'h99, 8'h12, 8'hBC, 8'hC0, 8'hC1, 8'hC2, 8'hC3}; send(s);
    drain_and_check("unsync");

    s = '{8'hBC, 8'hD0, 8'hD1}; send(s);
    step(1'b1, 1'b1, 8'hD2);
    @(posedge clk_4f);
    @(negedge clk_4f);
    chk("midreset_data", data_output, 32'h0);
    chk("midreset_count", 32'(error_count), 32'h0);
    drain_and_check("midreset");

    for (int i = 0; i < 300; i++) begin
      s = '{8'hBC, 8'h5A}; send(s);
    end
    drain_and_check("saturate");
    chk("saturate_ff", 32'(error_count), 32'hFF);

    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      logic       r, a;
      logic [7:0] d;
      r = ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 19) != 0);
      d = ($urandom_range(0, 4) == 0) ? 8'hBC : 8'($urandom);
      step(r, a, d);
    end
    drain_and_check("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
